// File: rtl/rb_arb_pkg.sv
// rtl/rb_arb_pkg.sv - shared constants and state type for the ring-buffer write arbiter
package rb_arb_pkg;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int SEL_W = 2;

    // Requester 0 gets top priority out of reset because the search starts at last_sel+1
    localparam logic [SEL_W-1:0] RST_LAST_SEL = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - 4-way round-robin pick (fixed priority when RR_ARB_FIXED_PRIO_EN is defined)
module rr_pick4
    import rb_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last_sel,
    input  logic             block,
    output logic [NREQ-1:0]  ack,
    output logic [SEL_W-1:0] win_sel,
    output logic             any
);

    // Find the first set request in search order; nothing is granted while blocked
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        found   = 1'b0;
        idx     = '0;
        ack     = '0;
        win_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef RR_ARB_FIXED_PRIO_EN
            idx = SEL_W'(k);
`else
            idx = last_sel + SEL_W'(k + 1);
`endif
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_sel = idx;
            end
        end
        if (found && !block) begin
            ack[win_sel] = 1'b1;
        end
        any = |ack;
    end

`ifdef RR_ARB_FIXED_PRIO_EN
    // last_sel is still tracked by the top level but plays no part in fixed priority
    logic unused_last_sel;
    assign unused_last_sel = ^last_sel;
`endif

endmodule

// File: rtl/rr_write_arbiter.sv
// rtl/rr_write_arbiter.sv - shares one ring-buffer write port between 4 byte producers; option macro RR_ARB_FIXED_PRIO_EN
module rr_write_arbiter
    import rb_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din,
    input  logic                 full,
    output logic [NREQ-1:0]      ack,
    output logic                 wr_en,
    output logic [DW-1:0]        wr_data,
    output logic [SEL_W-1:0]     last_sel
);

    wr_state_e        state;
    wr_state_e        state_next;
    logic [SEL_W-1:0] win_sel;
    logic             any;
    logic [DW-1:0]    sel_byte;

    // Reset counts as a block so a request held across reset is never acked
    rr_pick4 u_pick (
        .req      (req),
        .last_sel (last_sel),
        .block    (full | rst),
        .ack      (ack),
        .win_sel  (win_sel),
        .any      (any)
    );

    // Steer the winning requester's byte toward the write data register
    always_comb begin
        sel_byte = din[DW*win_sel +: DW];
    end

    // State register: WRITE means a byte was registered for the ring buffer last edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one write per granted cycle, no multi-cycle hold
    always_comb begin
        state_next = IDLE;
        if (any) begin
            state_next = WRITE;
        end
    end

    // Output decode: the write strobe is the registered state
    always_comb begin
        wr_en = (state == WRITE);
    end

    // Capture the granted byte and winner; both hold when nothing is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data  <= '0;
            last_sel <= RST_LAST_SEL;
        end else if (any) begin
            wr_data  <= sel_byte;
            last_sel <= win_sel;
        end
    end

endmodule

// File: doc/rr_write_arbiter.md
Name: rr_write_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit ring-buffer write port between 4 byte producers.
- Each cycle it picks at most one requester and steers that requester's byte through a 4:1 byte select.
- Sends the picked byte to the BRAM ring-buffer write interface as a registered write strobe plus data.
- Applies back-pressure by withholding grants while the buffer reports full.

Parameters:
- DW, 8, data width per requester and of the write port.
- NREQ, 4, number of requesters; fixed at 4 (2-bit select).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  req[i]=1: requester i has a byte pending; held until ack[i]
- din  in  32  packed bytes; requester i on din[8*i+7:8*i]
- full  in  1  ring buffer cannot accept a write this cycle
- ack  out  4  one-hot, combinational; ack[i]=1 means requester i's byte is taken at this clock edge
- wr_en  out  1  registered write strobe to ring buffer
- wr_data  out  8  registered write data
- last_sel  out  2  index of most recently granted requester (registered)

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_en=0, wr_data=8'h00.
  - last_sel=2'd3, so requester 0 has top priority after reset.
  - rst overrides all activity; a request pending during reset is not acked and must stay asserted.
- Grant decision (combinational, each cycle):
  - If full=1 or req==0: ack=4'b0000.
  - Otherwise: search order is last_sel+1, +2, +3, +4 (mod 4), wrapping 3→0; the first index with req set wins, and ack=one-hot of that index.
  - ack is never asserted while rst=1.
- On a clock edge with a winner w:
  - wr_en<=1, wr_data<=din[8*w+:8], last_sel<=w.
- On a clock edge with no winner:
  - wr_en<=0, wr_data holds its previous value, last_sel unchanged.
- Latency: a byte acked in cycle N appears on wr_en/wr_data in cycle N+1; one write per cycle maximum, so full throughput is 1 byte/cycle.
- Fairness:
  - With all 4 requesting continuously, grants rotate 0,1,2,3,0,...
  - A requester waits at most 3 grant cycles (excluding full cycles).
- Single requester: it is granted every cycle it requests; last_sel tracks it.
- full rising:
  - No ack that cycle.
  - A write already registered (wr_en=1 in the same cycle) is still valid; the ring buffer's full threshold must leave 1 entry of slack.
- full toggling: the pointer does not advance during full cycles, so priority resumes where it stopped.
- Requester dropping req before ack: allowed; it is simply not considered. Data on din is sampled only on the ack edge.
- Internal structure: a two-state view, IDLE (wr_en=0) and WRITE (wr_en=1); the next state is WRITE iff any ack is set. There is no multi-cycle lock.

Optional Feature:
- Macro: RR_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, requester 0 highest, 3 lowest.
  - last_sel still updates but does not affect selection.
  - The starvation bound does not apply.
- Undefined: round-robin as specified above (default build).

Decomposition:
- Shared package rb_arb_pkg holds:
  - NREQ=4, DW=8, SEL_W=2.
  - RST_LAST_SEL=2'd3.
  - An enum for IDLE/WRITE.
- One natural sub-module: rr_pick4.
  - Purely combinational.
  - Inputs: req[3:0], last_sel[1:0], block (=full).
  - Outputs: ack one-hot, win_sel[1:0], any.
  - Holds the rotate-and-find-first logic and the RR_ARB_FIXED_PRIO_EN variant.
- The top level holds registers and the byte select.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 → wr_en=0, wr_data=00, last_sel=3, ack=0.
- All requesting:
  - Stimulus: req=4'b1111, din bytes AA/BB/CC/DD for requesters 0..3, full=0 for 8 cycles.
  - Required: ack sequence 0001,0010,0100,1000 repeating; wr_data sequence AA,BB,CC,DD,AA... each one cycle after its ack.
- Wrap-around: last_sel=2 (after granting requester 2), req=4'b0011 → ack=0001 (requester 0), next cycle ack=0010.
- Full back-pressure:
  - Stimulus: req=1111, full=1 for 3 cycles mid-sequence after granting requester 1.
  - Required: ack=0 and wr_en=0 after one cycle; last_sel stays 1; when full=0, ack=0100.
- Reset mid-operation: rst=1 while wr_en=1 and req=1111 → next edge wr_en=0, last_sel=3, ack=0; after release, first ack=0001.
- Fixed priority build:
  - Stimulus: RR_ARB_FIXED_PRIO_EN defined, req=1111 for 4 cycles.
  - Required: ack=0001 every cycle; with req=1110 → ack=0010.
